// File: rtl/full_adder_bist.sv
// Built-in self test for a 1-bit full adder: walks all eight {a,b,cin} vectors,
// compares the adder's sum/cout with locally computed values, and reports a result.
module full_adder_bist #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_cin,
    input  logic             dut_sum,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       first_fail_vec,
    output logic             first_fail_valid
);
    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;
    // With no settle time every vector goes straight to the compare cycle.
    localparam state_t           VEC_START = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;

    state_t           state, state_nxt;
    logic [2:0]       vec;
    logic [3:0]       wait_cnt;
    logic             exp_sum, exp_cout, mismatch, accept;
    logic [ERR_W-1:0] err_nxt;

    assign {dut_a, dut_b, dut_cin} = vec;

    assign exp_sum  = ^vec;
    assign exp_cout = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
    assign mismatch = (dut_sum != exp_sum) || (dut_cout != exp_cout);
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign err_nxt  = (mismatch && (err_count != ERR_MAX)) ? err_count + ERR_W'(1) : err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = VEC_START;
            SETTLE:     if (wait_cnt <= 4'd1) state_nxt = CHECK;
            CHECK:      state_nxt = (vec == 3'd7) ? DONE : VEC_START;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec              <= '0;
            wait_cnt         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (accept) begin
            vec              <= '0;
            wait_cnt         <= SETTLE_LD;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                SETTLE: wait_cnt <= wait_cnt - 4'd1;
                CHECK: begin
                    err_count <= err_nxt;
                    if (mismatch && !first_fail_valid) begin
                        first_fail_vec   <= vec;
                        first_fail_valid <= 1'b1;
                    end
                    // pass must include the verdict of the last vector itself
                    if (vec == 3'd7) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_nxt == '0);
                    end else begin
                        vec      <= vec + 3'd1;
                        wait_cnt <= SETTLE_LD;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
